sigma_delta_adc: RTL
====================

Name: sigma_delta_adc

Overview:
- First-order sigma-delta ADC receiver. It is the input-side counterpart of the team's hybrid PWM/sigma-delta DAC.
- An external comparator compares the analogue input against an RC-filtered copy of fb_out. The block closes the loop by driving fb_out.
- The resulting 1-bit stream is decimated by a 2nd-order CIC (sinc2) filter. The block emits unsigned signalwidth-bit samples with a single-cycle valid strobe.

Parameters:
signalwidth, 16, output sample width in bits.
decbits, 8, log2 of the decimation ratio R (R = 2^decbits). Constraint: 2*decbits >= signalwidth; the bench checks this at elaboration.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
comp_in  input  1  raw comparator output, asynchronous to clk
fb_out  output  1  feedback drive to the external RC network
q  output  signalwidth  unsigned decimated sample
q_valid  output  1  one-cycle strobe; q is new when this is high

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n). On assertion, every register below clears to 0 and the state goes to WARMUP.
  - Registers cleared: s1, s2, decctr, int1, int2, z1, z2, q, q_valid, warmctr.
  - Outputs held at reset: fb_out=0, q=0, q_valid=0.
- Synchroniser and feedback:
  - s1 <= comp_in and s2 <= s1 every clock.
  - fb_out is the s2 flop output directly, with no extra register. Latency from comp_in to fb_out is 2 clocks.
  - Loop bit b = s2. The polarity is non-inverting: when the input is above the feedback level, comp=1 and fb_out goes high.
- Integrators run every clock. Width W = 2*decbits+1; arithmetic is modulo 2^W and wrap is intentional.
  - int1_next = int1 + b.
  - int2_next = int2 + int1_next.
- Decimation counter:
  - decctr is decbits wide, increments every clock and wraps R-1 -> 0.
  - tick = (decctr == R-1).
- Comb stage, updated on tick edges only, W bits:
  - diff1 = int2_next - z1; z1 <= int2_next.
  - diff2 = diff1 - z2; z2 <= diff1.
  - diff2 is in the range 0..R^2 inclusive.
- Scaling:
  - sat = (diff2 >= 2^(2*decbits)) ? 2^(2*decbits)-1 : diff2[2*decbits-1:0].
  - qnext = sat[2*decbits-1 : 2*decbits-signalwidth], i.e. truncation with no rounding.
- State machine:
  - WARMUP: on each tick, warmctr increments. The comb still updates, but q and q_valid are not touched. After the 2nd tick, go to RUN. Two ticks flush z1/z2 of start-up garbage.
  - RUN: on each tick edge, q <= qnext and q_valid <= 1.
  - On all other edges, q_valid <= 0 while q holds its value.
  - q_valid is therefore high for exactly 1 cycle every R cycles. There is no backpressure; a consumer that misses the strobe loses the sample.
- Timing:
  - The first q_valid is high in the cycle after the 3rd tick following reset release.
  - With decbits=8: ticks at cycles 255, 511, 767 (cycle 0 is the first edge after reset release), so q_valid is high at cycle 768.
- Boundary conditions:
  - All-ones stream gives diff2 = R^2, which saturates to all-ones.
  - All-zeros stream gives 0.
  - Reset asserted mid-sample aborts the partial sample, returns to WARMUP and suppresses q_valid immediately.
  - Metastable comp_in is absorbed by s1; only s2 is used.

Test Plan:
- comp_in held 1 from reset (decbits=8, signalwidth=16) -> q_valid first high at cycle 768; q=16'hFFFF (saturated from 65536); repeats every 256 cycles.
- comp_in held 0 -> q=16'h0000 on every strobe; fb_out stays 0.
- comp_in toggled 1,0,1,0 every clock -> q=16'h8000 exactly on every RUN strobe. Also check that fb_out follows comp_in delayed by 2 clocks.
- comp_in pattern 1,0,0,0 repeating -> q=16'h4000. Pattern 1,1,1,0 repeating -> q=16'hC000.
- Closed loop, with a behavioural RC model fb_out->comparator and a DC input at 0.3 of full scale -> q settles within ±2 LSB·2^(16-decbits) of 0x4CCC. Also run long enough (>2^17 cycles) to confirm integrator wrap causes no output glitch.
- Pulse reset_n low at cycle 600, then release -> q=0 and q_valid=0 immediately. The next q_valid comes 768 cycles after release; no strobe occurs during the 2 warm-up ticks.

Source files
------------

// File: rtl/sigma_delta_adc.sv
// rtl/sigma_delta_adc.sv - first-order sigma-delta ADC receiver with sinc2 decimator
//
// Closes a first-order sigma-delta loop around an external comparator and RC
// network, then decimates the 1-bit stream by R = 2^decbits with a
// 2nd-order CIC filter.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   comp_in  raw comparator output, asynchronous to clk
//   fb_out   feedback drive to the external RC network (synchronised comparator bit)
//   q        unsigned decimated sample, signalwidth bits
//   q_valid  one-cycle strobe, high when q has just been updated
module sigma_delta_adc #(
  parameter int signalwidth = 16,
  parameter int decbits     = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   comp_in,
  output logic                   fb_out,
  output logic [signalwidth-1:0] q,
  output logic                   q_valid
);

  // Integrator/comb width: enough to hold R^2 plus one bit, wrap is harmless
  // because the comb differences are taken modulo the same width.
  localparam int W  = 2*decbits + 1;
  localparam int SW = 2*decbits;

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  logic                   r_s1;
  logic                   r_s2;
  logic [decbits-1:0]     r_decctr;
  logic [W-1:0]           r_int1;
  logic [W-1:0]           r_int2;
  logic [W-1:0]           r_z1;
  logic [W-1:0]           r_z2;
  logic [signalwidth-1:0] r_q;
  logic                   r_q_valid;
  logic [1:0]             r_warmctr;
  logic [0:0]             r_state;

  logic                   w_tick;
  logic [W-1:0]           w_int1_next;
  logic [W-1:0]           w_int2_next;
  logic [W-1:0]           w_diff1;
  logic [W-1:0]           w_diff2;
  logic [SW-1:0]          w_sat;
  logic [signalwidth-1:0] w_qnext;

  // decctr is exactly decbits wide, so all-ones is R-1 and it wraps to 0 by itself.
  assign w_tick      = (r_decctr == {decbits{1'b1}});

  // r_s2 is the loop bit; r_s1 only absorbs metastability and is never used directly.
  assign w_int1_next = r_int1 + {{(W-1){1'b0}}, r_s2};
  assign w_int2_next = r_int2 + w_int1_next;
  assign w_diff1     = w_int2_next - r_z1;
  assign w_diff2     = w_diff1 - r_z2;

  // Valid diff2 never exceeds R^2 = 2^(2*decbits), so the top bit alone flags
  // the single value that would overflow the output range.
  assign w_sat       = w_diff2[W-1] ? {SW{1'b1}} : w_diff2[SW-1:0];
  assign w_qnext     = w_sat[SW-1 -: signalwidth];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_decctr  <= '0;
      r_int1    <= '0;
      r_int2    <= '0;
      r_z1      <= '0;
      r_z2      <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_warmctr <= 2'd0;
      r_state   <= ST_WARMUP;
    end else begin
      r_s1      <= comp_in;
      r_s2      <= r_s1;
      r_decctr  <= r_decctr + {{(decbits-1){1'b0}}, 1'b1};
      r_int1    <= w_int1_next;
      r_int2    <= w_int2_next;
      r_q_valid <= 1'b0;
      if (w_tick) begin
        r_z1 <= w_int2_next;
        r_z2 <= w_diff1;
        if (r_state == ST_WARMUP) begin
          // Two ticks flush the comb delays of start-up content before any sample is emitted.
          r_warmctr <= r_warmctr + 2'd1;
          if (r_warmctr == 2'd1) begin
            r_state <= ST_RUN;
          end
        end else begin
          r_q       <= w_qnext;
          r_q_valid <= 1'b1;
        end
      end
    end
  end

  assign fb_out  = r_s2;
  assign q       = r_q;
  assign q_valid = r_q_valid;

endmodule
